// File: rtl/map_palette_fader.sv
// Palette fader for the map layer: darkens the palette ROM colour by a
// frame-paced fade level that steps between full colour and black.
module map_palette_fader #(
    parameter int unsigned FRAMES_PER_STEP = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       fade_out_req,
    input  logic       fade_in_req,
    input  logic [3:0] pix_index,
    output logic [3:0] pal_index,
    input  logic [3:0] base_red,
    input  logic [3:0] base_green,
    input  logic [3:0] base_blue,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic [3:0] fade_level,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        CLEAR,
        FADING_OUT,
        DARK,
        FADING_IN
    } state_t;

    localparam logic [7:0] STEP_LAST = 8'(FRAMES_PER_STEP);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] level_q, level_d;
    logic       done_q, done_d;
    logic [3:0] red_q, red_d;
    logic [3:0] green_q, green_d;
    logic [3:0] blue_q, blue_d;

    logic       in_req_eff;
    logic [7:0] cnt_inc;
    logic       step_hit;

    function automatic logic [3:0] sat_sub(input logic [3:0] base, input logic [3:0] lvl);
        return (base > lvl) ? (base - lvl) : 4'd0;
    endfunction

    assign pal_index  = pix_index;
    assign fade_level = level_q;
    assign busy       = (state_q == FADING_OUT) || (state_q == FADING_IN);
    assign done       = done_q;
    assign red        = red_q;
    assign green      = green_q;
    assign blue       = blue_q;

    // A simultaneous fade-out request masks fade-in everywhere.
    assign in_req_eff = fade_in_req & ~fade_out_req;
    assign cnt_inc    = cnt_q + 8'd1;
    assign step_hit   = frame_tick && (cnt_inc == STEP_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        done_d  = 1'b0;
        red_d   = sat_sub(base_red, level_q);
        green_d = sat_sub(base_green, level_q);
        blue_d  = sat_sub(base_blue, level_q);

        unique case (state_q)
            CLEAR: begin
                if (fade_out_req) begin
                    state_d = FADING_OUT;
                    cnt_d   = '0;
                end
            end
            DARK: begin
                if (in_req_eff) begin
                    state_d = FADING_IN;
                    cnt_d   = '0;
                end
            end
            FADING_OUT: begin
                if (in_req_eff) begin
                    state_d = FADING_IN;
                    cnt_d   = '0;
                end else if (frame_tick) begin
                    if (step_hit) begin
                        cnt_d = '0;
                        // Saturate at black even if a reversal started at 15.
                        if (level_q >= 4'd14) begin
                            level_d = 4'd15;
                            state_d = DARK;
                            done_d  = 1'b1;
                        end else begin
                            level_d = level_q + 4'd1;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            FADING_IN: begin
                if (fade_out_req) begin
                    state_d = FADING_OUT;
                    cnt_d   = '0;
                end else if (frame_tick) begin
                    if (step_hit) begin
                        cnt_d = '0;
                        if (level_q <= 4'd1) begin
                            level_d = 4'd0;
                            state_d = CLEAR;
                            done_d  = 1'b1;
                        end else begin
                            level_d = level_q - 4'd1;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
                level_d = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            level_q <= '0;
            done_q  <= 1'b0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            done_q  <= done_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
        end
    end

endmodule

// File: tb/tb_map_palette_fader.sv
// Bench for map_palette_fader: fade arithmetic model checked every cycle,
// plus directed scenario expectations pinned at key points.
module tb_map_palette_fader;

    localparam int FPS = 2;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       fade_out_req = 1'b0;
    logic       fade_in_req = 1'b0;
    logic [3:0] pix_index = 4'd3;
    logic [3:0] pal_index;
    logic [3:0] base_red, base_green, base_blue;
    logic [3:0] red, green, blue, fade_level;
    logic       busy, done;

    logic [3:0] rom_r [16];
    logic [3:0] rom_g [16];
    logic [3:0] rom_b [16];

    assign base_red   = rom_r[pal_index];
    assign base_green = rom_g[pal_index];
    assign base_blue  = rom_b[pal_index];

    map_palette_fader #(.FRAMES_PER_STEP(FPS)) dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
        .fade_out_req(fade_out_req), .fade_in_req(fade_in_req),
        .pix_index(pix_index), .pal_index(pal_index),
        .base_red(base_red), .base_green(base_green), .base_blue(base_blue),
        .red(red), .green(green), .blue(blue),
        .fade_level(fade_level), .busy(busy), .done(done)
    );

    always #5 Clk = ~Clk;

    // Model: level = start +/- (counted ticks since fade began) / FPS.
    // mode 0 clear, 1 fading out, 2 dark, 3 fading in
    int         m_mode = 0, m_level = 0, m_start = 0, m_ticks = 0;
    logic       m_done = 1'b0;
    logic [3:0] m_r = '0, m_g = '0, m_b = '0;

    function automatic logic [3:0] sat(input logic [3:0] b, input int lvl);
        int v;
        v = int'(b) - lvl;
        return (v < 0) ? 4'd0 : 4'(v);
    endfunction

    always @(posedge Clk or posedge Reset) begin : model_blk
        int   mode, lvl, st, tk;
        logic dn;
        if (Reset) begin
            m_mode <= 0; m_level <= 0; m_start <= 0; m_ticks <= 0;
            m_done <= 1'b0; m_r <= '0; m_g <= '0; m_b <= '0;
        end else begin
            mode = m_mode; lvl = m_level; st = m_start; tk = m_ticks; dn = 1'b0;
            if ((mode == 0 || mode == 3) && fade_out_req) begin
                mode = 1; st = lvl; tk = 0;
            end else if ((mode == 2 || mode == 1) && fade_in_req && !fade_out_req) begin
                mode = 3; st = lvl; tk = 0;
            end else if ((mode == 1 || mode == 3) && frame_tick) begin
                tk = tk + 1;
                if (mode == 1) begin
                    lvl = st + tk / FPS;
                    if (lvl >= 15) begin lvl = 15; mode = 2; dn = 1'b1; end
                end else begin
                    lvl = st - tk / FPS;
                    if (lvl <= 0) begin lvl = 0; mode = 0; dn = 1'b1; end
                end
            end
            m_r <= sat(rom_r[pix_index], m_level);
            m_g <= sat(rom_g[pix_index], m_level);
            m_b <= sat(rom_b[pix_index], m_level);
            m_mode <= mode; m_level <= lvl; m_start <= st; m_ticks <= tk; m_done <= dn;
        end
    end

    typedef struct {
        string name;
        int    sel;  // 0 level, 1 red, 2 green, 3 blue, 4 busy, 5 done pulses seen
        int    exp;
    } pin_t;
    pin_t pins[$];

    int checks = 0, errors = 0, dut_dones = 0;

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin : compare_blk
        pin_t p;
        int   act;
        if (done) dut_dones++;
        cmp("pal_index", int'(pal_index), int'(pix_index));
        cmp("fade_level", int'(fade_level), m_level);
        cmp("red", int'(red), int'(m_r));
        cmp("green", int'(green), int'(m_g));
        cmp("blue", int'(blue), int'(m_b));
        cmp("busy", int'(busy), (m_mode == 1 || m_mode == 3) ? 1 : 0);
        cmp("done", int'(done), int'(m_done));
        while (pins.size() > 0) begin
            p = pins.pop_front();
            case (p.sel)
                0: act = int'(fade_level);
                1: act = int'(red);
                2: act = int'(green);
                3: act = int'(blue);
                4: act = int'(busy);
                default: act = dut_dones;
            endcase
            cmp(p.name, act, p.exp);
        end
    end

    task automatic cyc(input logic t, input logic o, input logic i);
        @(negedge Clk);
        #1;
        frame_tick = t; fade_out_req = o; fade_in_req = i;
    endtask

    task automatic pin(input string n, input int s, input int e);
        pins.push_back('{n, s, e});
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            cyc(1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            rom_r[i] = 4'(i);
            rom_g[i] = 4'(15 - i);
            rom_b[i] = 4'(i * 7);
        end
        rom_r[3] = 4'hC; rom_g[3] = 4'hA; rom_b[3] = 4'h9;

        // Reset held with requests active
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        pin("rst_level", 0, 0); pin("rst_red", 1, 0); pin("rst_busy", 4, 0);
        cyc(1'b0, 1'b0, 1'b0);
        Reset = 1'b0;

        // Ignored fade-in and ticks while clear
        cyc(1'b1, 1'b0, 1'b1);
        pin("clear_fadein_busy", 4, 0); pin("clear_fadein_level", 0, 0);
        cyc(1'b1, 1'b0, 0);

        // Both requests with a tick: fade-out wins, tick not counted
        cyc(1'b1, 1'b1, 1'b1);
        pin("both_busy", 4, 1); pin("both_level", 0, 0);
        ticks(1);
        pin("first_tick_level", 0, 0);
        ticks(1);
        pin("second_tick_level", 0, 1);
        ticks(8);
        pin("lvl5_red", 1, 7); pin("lvl5_green", 2, 5); pin("lvl5_blue", 3, 4);
        ticks(12);
        pin("lvl11_level", 0, 11);
        pin("lvl11_red", 1, 1); pin("lvl11_green", 2, 0); pin("lvl11_blue", 3, 0);
        ticks(7);
        cyc(1'b1, 1'b0, 1'b0);
        pin("dark_level", 0, 15); pin("dark_busy", 4, 0); pin("dark_dones", 5, 1);
        cyc(1'b0, 1'b0, 1'b0);
        pin("dark_red", 1, 0); pin("dark_green", 2, 0); pin("dark_blue", 3, 0);
        pin("dark_dones_once", 5, 1);

        // Ignored fade-out while dark
        cyc(1'b1, 1'b1, 1'b0);
        pin("dark_fadeout_busy", 4, 0); pin("dark_fadeout_level", 0, 15);
        cyc(1'b0, 1'b0, 1'b0);
        pin("dark_fadeout_dones", 5, 1);

        // Fade in to level 9 then reset mid-fade
        cyc(1'b0, 1'b0, 1'b1);
        pin("fadein_busy", 4, 1);
        ticks(12);
        pin("fadein_lvl9", 0, 9);
        cyc(1'b0, 1'b0, 1'b0);
        Reset = 1'b1;
        pin("midrst_level", 0, 0); pin("midrst_busy", 4, 0); pin("midrst_red", 1, 0);
        cyc(1'b0, 1'b0, 1'b0);
        Reset = 1'b0;
        pin("midrst_dones", 5, 1);

        // Fade out to 6, reverse with a tick, fade back to clear
        cyc(1'b0, 1'b1, 1'b0);
        ticks(12);
        pin("rev_lvl6", 0, 6);
        cyc(1'b1, 1'b0, 1'b1);
        pin("rev_busy", 4, 1); pin("rev_hold6", 0, 6);
        ticks(1);
        pin("rev_tick1_lvl", 0, 6);
        ticks(11);
        pin("rev_end_level", 0, 0); pin("rev_end_busy", 4, 0); pin("rev_end_dones", 5, 2);

        // Reverse a fade-in back into a fade-out
        cyc(1'b0, 1'b1, 1'b0);
        ticks(4);
        cyc(1'b0, 1'b0, 1'b1);
        pin("in_rev_lvl2", 0, 2);
        ticks(2);
        cyc(1'b1, 1'b1, 1'b0);
        pin("out_rev_busy", 4, 1); pin("out_rev_lvl1", 0, 1);
        ticks(2);
        pin("out_rev_lvl2", 0, 2);

        // Sweep palette indices mid-fade
        for (int k = 0; k < 16; k++) begin
            pix_index = 4'(k);
            cyc((k % 3) == 0, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
